// File: rtl/streamer_rx_checker_pkg.sv
// Shared types and helpers for the RX streamer block checker.
// The block checker's optional throttle is enabled by defining STREAMER_RX_CHECKER_THROTTLE_EN.
package streamer_rx_checker_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_BLOCK = 1'b1
  } state_t;

  localparam int unsigned c_sat_cnt_width  = 16;
  localparam int unsigned c_wrap_cnt_width = 32;

  // Adds a small step to a 16-bit value and clips the result at 0xFFFF.
  // A step of 2 is used when a lost event and a framing error share a cycle.
  function automatic logic [c_sat_cnt_width-1:0] sat_inc16(
    input logic [c_sat_cnt_width-1:0] value,
    input logic [1:0]                 step
  );
    logic [c_sat_cnt_width:0] sum;
    sum = {1'b0, value} + {{(c_sat_cnt_width-1){1'b0}}, step};
    return sum[c_sat_cnt_width] ? {c_sat_cnt_width{1'b1}} : sum[c_sat_cnt_width-1:0];
  endfunction

endpackage

// File: rtl/streamer_rx_checker_sat_cnt.sv
// 16-bit saturating event counter with a synchronous clear that wins over inc.
module streamer_rx_checker_sat_cnt
  import streamer_rx_checker_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic [1:0]                 inc,
  output logic [c_sat_cnt_width-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc != 2'd0) begin
      count <= sat_inc16(count, inc);
    end
  end

endmodule

// File: rtl/streamer_rx_block_checker.sv
// Consumes framed words from the RX streamer, checks the counter test pattern and
// block sizes, and keeps statistics. Optional throttle: STREAMER_RX_CHECKER_THROTTLE_EN.
module streamer_rx_block_checker
  import streamer_rx_checker_pkg::*;
#(
  parameter int g_data_width     = 64,
  parameter int g_block_size_min = 1,
  parameter int g_block_size_max = 3
) (
  input  logic                        clk_sys_i,
  input  logic                        rst_n_i,
  input  logic [g_data_width-1:0]     rx_data_i,
  input  logic                        rx_valid_i,
  input  logic                        rx_first_p1_i,
  input  logic                        rx_last_p1_i,
  input  logic                        rx_lost_p1_i,
  output logic                        rx_dreq_o,
  input  logic                        clr_i,
  output logic                        blk_done_p1_o,
  output logic [c_sat_cnt_width-1:0]  blk_size_o,
  output logic                        err_p1_o,
  output logic [c_wrap_cnt_width-1:0] cnt_blocks_o,
  output logic [c_wrap_cnt_width-1:0] cnt_words_o,
  output logic [c_sat_cnt_width-1:0]  cnt_seq_err_o,
  output logic [c_sat_cnt_width-1:0]  cnt_frame_err_o,
  output logic [c_sat_cnt_width-1:0]  cnt_size_err_o
);

  localparam logic [c_sat_cnt_width-1:0] c_size_min = c_sat_cnt_width'(g_block_size_min);
  localparam logic [c_sat_cnt_width-1:0] c_size_max = c_sat_cnt_width'(g_block_size_max);
  localparam logic [c_sat_cnt_width-1:0] c_size_one = c_sat_cnt_width'(1);
  localparam logic [g_data_width-1:0]    c_data_one = g_data_width'(1);

  state_t                     state, state_eff, state_next;
  logic [c_sat_cnt_width-1:0] size, size_next, done_size;
  logic [g_data_width-1:0]    expected;
  logic                       synced, synced_eff;

  logic       seq_err, frame_word, size_err, done;
  logic [1:0] frame_inc, seq_inc, size_inc;

  // A lost event acts first: the partial block and the sync are dropped before
  // a word arriving in the same cycle is looked at.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    state_eff  = rx_lost_p1_i ? IDLE : state;
    synced_eff = synced & ~rx_lost_p1_i;
    state_next = state_eff;
    size_next  = size;
    done_size  = size;
    done       = 1'b0;
    seq_err    = 1'b0;
    frame_word = 1'b0;

    if (rx_valid_i) begin
      seq_err = synced_eff && (rx_data_i != expected);
      if (rx_first_p1_i) begin
        // A first inside a block truncates the old block without a done strobe.
        frame_word = (state_eff == IN_BLOCK);
        size_next  = c_size_one;
        done_size  = c_size_one;
        if (rx_last_p1_i) begin
          done       = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = IN_BLOCK;
        end
      end else if (state_eff == IDLE) begin
        frame_word = 1'b1;
      end else begin
        done_size = sat_inc16(size, 2'd1);
        size_next = done_size;
        if (rx_last_p1_i) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
    end

    size_err  = done && ((done_size < c_size_min) || (done_size > c_size_max));
    frame_inc = {1'b0, rx_lost_p1_i} + {1'b0, frame_word};
    seq_inc   = {1'b0, seq_err};
    size_inc  = {1'b0, size_err};
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      size          <= '0;
      expected      <= '0;
      synced        <= 1'b0;
      blk_done_p1_o <= 1'b0;
      blk_size_o    <= '0;
      err_p1_o      <= 1'b0;
      cnt_blocks_o  <= '0;
      cnt_words_o   <= '0;
    end else begin
      blk_done_p1_o <= 1'b0;
      err_p1_o      <= 1'b0;
      if (clr_i) begin
        state        <= IDLE;
        size         <= '0;
        synced       <= 1'b0;
        blk_size_o   <= '0;
        cnt_blocks_o <= '0;
        cnt_words_o  <= '0;
      end else begin
        state    <= state_next;
        size     <= size_next;
        err_p1_o <= seq_err | frame_word | size_err | rx_lost_p1_i;
        if (rx_valid_i) begin
          expected    <= rx_data_i + c_data_one;
          synced      <= 1'b1;
          cnt_words_o <= cnt_words_o + 32'd1;
        end else if (rx_lost_p1_i) begin
          synced <= 1'b0;
        end
        if (done) begin
          blk_done_p1_o <= 1'b1;
          blk_size_o    <= done_size;
          cnt_blocks_o  <= cnt_blocks_o + 32'd1;
        end
      end
    end
  end

`ifdef STREAMER_RX_CHECKER_THROTTLE_EN
  logic [1:0] throttle_cnt;

  // Request is withheld one cycle in four; words arriving meanwhile are still taken.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      throttle_cnt <= 2'd0;
      rx_dreq_o    <= 1'b0;
    end else begin
      throttle_cnt <= throttle_cnt + 2'd1;
      rx_dreq_o    <= (throttle_cnt != 2'd3);
    end
  end
`else
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_dreq_o <= 1'b0;
    end else begin
      rx_dreq_o <= 1'b1;
    end
  end
`endif

  streamer_rx_checker_sat_cnt u_cnt_seq_err (
    .clk   (clk_sys_i),
    .rst_n (rst_n_i),
    .clr   (clr_i),
    .inc   (seq_inc),
    .count (cnt_seq_err_o)
  );

  streamer_rx_checker_sat_cnt u_cnt_frame_err (
    .clk   (clk_sys_i),
    .rst_n (rst_n_i),
    .clr   (clr_i),
    .inc   (frame_inc),
    .count (cnt_frame_err_o)
  );

  streamer_rx_checker_sat_cnt u_cnt_size_err (
    .clk   (clk_sys_i),
    .rst_n (rst_n_i),
    .clr   (clr_i),
    .inc   (size_inc),
    .count (cnt_size_err_o)
  );

endmodule

// File: tb/tb_streamer_rx_block_checker.sv
// Randomized and directed bench for streamer_rx_block_checker, compared every cycle
// against a block-queue reference model.
module tb_streamer_rx_block_checker;

  localparam int W    = 64;
  localparam int BMIN = 1;
  localparam int BMAX = 3;

  logic         clk_sys_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic [W-1:0] rx_data_i = '0;
  logic         rx_valid_i = 1'b0, rx_first_p1_i = 1'b0, rx_last_p1_i = 1'b0;
  logic         rx_lost_p1_i = 1'b0, clr_i = 1'b0;
  logic         rx_dreq_o, blk_done_p1_o, err_p1_o;
  logic [15:0]  blk_size_o, cnt_seq_err_o, cnt_frame_err_o, cnt_size_err_o;
  logic [31:0]  cnt_blocks_o, cnt_words_o;

  always #5 clk_sys_i = ~clk_sys_i;

  streamer_rx_block_checker #(
    .g_data_width     (W),
    .g_block_size_min (BMIN),
    .g_block_size_max (BMAX)
  ) dut (
    .clk_sys_i       (clk_sys_i),
    .rst_n_i         (rst_n_i),
    .rx_data_i       (rx_data_i),
    .rx_valid_i      (rx_valid_i),
    .rx_first_p1_i   (rx_first_p1_i),
    .rx_last_p1_i    (rx_last_p1_i),
    .rx_lost_p1_i    (rx_lost_p1_i),
    .rx_dreq_o       (rx_dreq_o),
    .clr_i           (clr_i),
    .blk_done_p1_o   (blk_done_p1_o),
    .blk_size_o      (blk_size_o),
    .err_p1_o        (err_p1_o),
    .cnt_blocks_o    (cnt_blocks_o),
    .cnt_words_o     (cnt_words_o),
    .cnt_seq_err_o   (cnt_seq_err_o),
    .cnt_frame_err_o (cnt_frame_err_o),
    .cnt_size_err_o  (cnt_size_err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Reference model: the open block is a queue of its words; empty queue = between blocks.
  logic [W-1:0] blk_q[$];
  logic [W-1:0] m_exp;
  bit           m_synced;
  bit           m_done, m_err;
  int           m_size, m_seq, m_frame, m_size_err, m_edges;
  logic [31:0]  m_blocks, m_words;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_reset();
    blk_q.delete();
    m_exp = '0; m_synced = 0; m_done = 0; m_err = 0;
    m_size = 0; m_seq = 0; m_frame = 0; m_size_err = 0; m_edges = 0;
    m_blocks = '0; m_words = '0;
  endtask

  task automatic model_step();
    m_edges++;
    m_done = 0;
    m_err  = 0;
    if (clr_i) begin
      blk_q.delete();
      m_synced = 0; m_size = 0; m_seq = 0; m_frame = 0; m_size_err = 0;
      m_blocks = '0; m_words = '0;
      return;
    end
    if (rx_lost_p1_i) begin
      m_frame = sat16(m_frame + 1);
      blk_q.delete();
      m_synced = 0;
      m_err = 1;
    end
    if (rx_valid_i) begin
      m_words = m_words + 1;
      if (m_synced && rx_data_i != m_exp) begin
        m_seq = sat16(m_seq + 1);
        m_err = 1;
      end
      m_exp = rx_data_i + 1;
      m_synced = 1;
      if (rx_first_p1_i) begin
        if (blk_q.size() != 0) begin
          m_frame = sat16(m_frame + 1);
          m_err = 1;
        end
        blk_q.delete();
        blk_q.push_back(rx_data_i);
      end else if (blk_q.size() == 0) begin
        m_frame = sat16(m_frame + 1);
        m_err = 1;
      end else begin
        blk_q.push_back(rx_data_i);
      end
      if (rx_last_p1_i && blk_q.size() != 0) begin
        m_done = 1;
        m_size = sat16(blk_q.size());
        m_blocks = m_blocks + 1;
        if (m_size < BMIN || m_size > BMAX) begin
          m_size_err = sat16(m_size_err + 1);
          m_err = 1;
        end
        blk_q.delete();
      end
    end
  endtask

  function automatic bit model_dreq();
    if (m_edges == 0) return 0;
`ifdef STREAMER_RX_CHECKER_THROTTLE_EN
    return ((m_edges - 1) % 4) != 3;
`else
    return 1;
`endif
  endfunction

  task automatic compare_all();
    check("blk_done",  blk_done_p1_o,   m_done);
    check("blk_size",  blk_size_o,      m_size);
    check("err",       err_p1_o,        m_err);
    check("blocks",    cnt_blocks_o,    m_blocks);
    check("words",     cnt_words_o,     m_words);
    check("seq_err",   cnt_seq_err_o,   m_seq);
    check("frame_err", cnt_frame_err_o, m_frame);
    check("size_err",  cnt_size_err_o,  m_size_err);
    check("dreq",      rx_dreq_o,       model_dreq());
  endtask

  // One clock: drive inputs, take the edge, then compare 1 time unit later.
  task automatic step(input bit v, input bit f, input bit l, input logic [W-1:0] d,
                      input bit lost = 0, input bit clr = 0);
    rx_valid_i = v; rx_first_p1_i = f; rx_last_p1_i = l; rx_data_i = d;
    rx_lost_p1_i = lost; clr_i = clr;
    @(posedge clk_sys_i);
    #1;
    model_step();
    compare_all();
    rx_valid_i = 0; rx_first_p1_i = 0; rx_last_p1_i = 0; rx_lost_p1_i = 0; clr_i = 0;
  endtask

  task automatic apply_reset();
    rst_n_i = 1'b0;
    #2;
    model_reset();
    compare_all();
    @(posedge clk_sys_i);
    #5;
    rst_n_i = 1'b1;
  endtask

  initial begin
    logic [W-1:0] d;
    bit v, f, l, lost, clr;

    // Reset state
    model_reset();
    repeat (2) @(posedge clk_sys_i);
    #1;
    compare_all();
    #4;
    rst_n_i = 1'b1;

    // Back-to-back blocks {0}, {1,2,3}, {4,5}
    step(1, 1, 1, 0);
    check("bb_size1", blk_size_o, 1);
    step(1, 1, 0, 1); step(1, 0, 0, 2); step(1, 0, 1, 3);
    check("bb_size3", blk_size_o, 3);
    step(1, 1, 0, 4); step(1, 0, 1, 5);
    check("bb_size2", blk_size_o, 2);
    check("bb_blocks", cnt_blocks_o, 3);
    check("bb_words", cnt_words_o, 6);
    check("bb_errs", {cnt_seq_err_o, cnt_frame_err_o, cnt_size_err_o}, 0);

    // Sequence error on the third word, then resync at 14
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 10); step(1, 0, 0, 11); step(1, 0, 1, 13);
    check("seq_strobe", err_p1_o, 1);
    check("seq_cnt", cnt_seq_err_o, 1);
    step(1, 1, 1, 14);
    check("seq_resync", err_p1_o, 0);

    // First inside a block
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0); step(1, 1, 1, 1);
    check("trunc_frame", cnt_frame_err_o, 1);
    check("trunc_size", blk_size_o, 1);

    // Oversized block
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0); step(1, 0, 0, 1); step(1, 0, 0, 2); step(1, 0, 1, 3);
    check("big_done", blk_done_p1_o, 1);
    check("big_size", blk_size_o, 4);
    check("big_err", cnt_size_err_o, 1);

    // Lost mid-block, then a fresh block with a jump in data
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0); step(1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 1, 0, 100); step(1, 0, 1, 101);
    check("lost_frame", cnt_frame_err_o, 1);
    check("lost_seq", cnt_seq_err_o, 0);
    check("lost_size", blk_size_o, 2);

    // Lost together with a stray word: two framing events in one cycle
    step(1, 0, 0, 7, 1);
    check("lost_stray", cnt_frame_err_o, 3);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      v    = ($urandom_range(3) != 0);
      f    = ($urandom_range(3) == 0);
      l    = ($urandom_range(2) == 0);
      lost = ($urandom_range(49) == 0);
      clr  = ($urandom_range(99) == 0);
      case ($urandom_range(15))
        0:       d = {$urandom, $urandom};
        1:       d = '1;
        default: d = m_exp;
      endcase
      step(v, f, l, d, lost, clr);
    end

    // Reset in the middle of a block: no done strobe afterwards
    step(1, 1, 0, 50); step(1, 0, 0, 51);
    apply_reset();
    step(1, 0, 1, 52);
    check("rst_no_done", blk_done_p1_o, 0);

    // Saturation of the sequence-error counter, then clear
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 70001; i++) step(1, 1, 1, 0);
    check("sat_seq", cnt_seq_err_o, 16'hFFFF);
    step(0, 0, 0, 0, 0, 1);
    check("clr_all", {cnt_blocks_o, cnt_words_o}, 0);
    check("clr_sat", {cnt_seq_err_o, cnt_frame_err_o, cnt_size_err_o}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/streamer_rx_block_checker.md
# streamer_rx_block_checker

Synthesizable client-side consumer for the RX streamer output. Accepts words framed by first/last strobes, reassembles them into blocks, and checks each block against the multiword test pattern: words carry consecutive counter values across block boundaries, and block sizes lie in a configured range. It sits directly on the RX streamer's rx_* interface, in hardware tests and on-board link soak tests, and exposes completion strobes, error strobes and statistics counters to a register bank.

## Interface
- g_data_width, 64: width of rx data word
- g_block_size_min, 1: smallest legal block size in words
- g_block_size_max, 3: largest legal block size in words
- clk_sys_i  in  1  system clock; the only clock
- rst_n_i  in  1  asynchronous active-low reset
- rx_data_i  in  g_data_width  received word
- rx_valid_i  in  1  word present this cycle
- rx_first_p1_i  in  1  word is first of block (qualified by rx_valid_i)
- rx_last_p1_i  in  1  word is last of block (qualified by rx_valid_i)
- rx_lost_p1_i  in  1  streamer reports lost frame(s)
- rx_dreq_o  out  1  data request to streamer
- clr_i  in  1  synchronous clear of all counters and sync state
- blk_done_p1_o  out  1  one-cycle strobe: well-framed block completed
- blk_size_o  out  16  size of last completed block
- err_p1_o  out  1  one-cycle strobe: any error detected this word/event
- cnt_blocks_o  out  32  completed blocks, wraps
- cnt_words_o  out  32  accepted words, wraps
- cnt_seq_err_o  out  16  sequence errors, saturating
- cnt_frame_err_o  out  16  framing errors plus lost events, saturating
- cnt_size_err_o  out  16  size-range errors, saturating

## Operation
- States: IDLE (between blocks) and IN_BLOCK. A 16-bit size register saturates at 0xFFFF. A g_data_width expected register and a synced flag are kept.
- Every cycle with rx_valid_i set is consumed, independent of rx_dreq_o. cnt_words_o increments.
- Sequence check, on every valid word: if synced=0, load expected=data+1 and set synced=1, with no error. If synced=1 and data!=expected, flag a sequence error. In both cases set expected=data+1, so the checker resyncs after a mismatch. Arithmetic is modulo 2^g_data_width.
- IDLE, first and last: block of size 1 completes.
- IDLE, first without last: size=1, go to IN_BLOCK.
- IDLE, word without first: framing error; the word is discarded from block accounting and the state stays IDLE.
- IN_BLOCK, first: framing error (previous block truncated, no done strobe). Restart with size=1. If last is also set, complete size 1; otherwise stay in IN_BLOCK.
- IN_BLOCK, no first, no last: size+1.
- IN_BLOCK, last without first: complete with size+1.
- Completion: blk_done_p1_o=1, blk_size_o=size, cnt_blocks_o+1. A size error is flagged if size<g_block_size_min or size>g_block_size_max; blk_done_p1_o still pulses.
- rx_lost_p1_i: framing-error count +1, state goes to IDLE, the partial block is dropped, synced=0.
- Lost and valid in the same cycle: the lost event is applied first, then the word is processed from IDLE with synced=0.
- err_p1_o = OR of the sequence, framing and size errors raised in that cycle.
- clr_i: all counters, size and synced go to 0, state goes to IDLE. clr_i has priority over a simultaneous word, which is ignored.
- Saturating counters hold at 0xFFFF.

## Timing
- All outputs are registered and update on the edge that samples the word or event, so strobes are visible one cycle after the input cycle.
- Reset values: every output is 0, including rx_dreq_o. State is IDLE and synced=0.
- rx_dreq_o goes to 1 on the first clk_sys_i edge after reset release. Without the configuration macro it stays at 1.
- Back-to-back blocks (last followed by first on the next cycle) are supported with no idle cycle.
- Asserting reset mid-block discards the block and does not produce a done strobe.

## Configuration
- STREAMER_RX_CHECKER_THROTTLE_EN defined: a free-running 2-bit counter starts at 0 after reset. rx_dreq_o=0 whenever the counter is 3, giving 3 requests in every 4 cycles. This exercises streamer backpressure. Words arriving while rx_dreq_o=0 are still accepted.
- Macro undefined: no throttle counter; rx_dreq_o is constant 1 after reset.

## Structure
- Package streamer_rx_checker_pkg holds:
  - the state enum (IDLE, IN_BLOCK);
  - the counter width constants (16 and 32);
  - a function for a saturating 16-bit increment.
- One sub-module, streamer_rx_checker_sat_cnt: a 16-bit saturating counter with inc and clr inputs, instantiated three times.

## Test plan
- Blocks {0}, {1,2,3}, {4,5} sent back-to-back → three blk_done_p1_o strobes with sizes 1, 3, 2; cnt_blocks_o=3, cnt_words_o=6, all error counters 0.
- Words 10, 11, 13 in one 3-word block after sync → cnt_seq_err_o=1, err_p1_o on the third word, then 14 is accepted without error.
- first on word 1 of {0,1} (IN_BLOCK, first again) → cnt_frame_err_o=1, no done for the first block; done with size 1 or 2 depending on last.
- 4-word block {0..3} with max=3 → blk_done_p1_o, blk_size_o=4, cnt_size_err_o=1.
- rx_lost_p1_i in mid-block, then the block {100,101} → frame count 1, no sequence error (resync), done size 2.
- 70000 sequence errors → cnt_seq_err_o holds 0xFFFF. A clr_i pulse then zeroes all counters. With THROTTLE_EN, rx_dreq_o reads 1,1,1,0 repeating from reset release.
